// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/stall controller.
// Stall reason codes, mult/div occupancy states and the hardwired-zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    SR_NONE    = 2'd0,
    SR_LOADUSE = 2'd1,
    SR_BRANCH  = 2'd2,
    SR_MDBUSY  = 2'd3
  } stall_reason_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A producer never aliases $0, which reads as constant zero.
  function automatic logic reg_match(
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (rd != REG_ZERO) && ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));
  endfunction

endpackage

// File: rtl/md_occupancy_fsm.sv
// Mult/div occupancy tracker: a start accepted on an edge holds md_busy high for exactly MD_CYCLES cycles.
// Registered output, one-edge latency from start; synchronous active-high reset abandons any operation.
module md_occupancy_fsm
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      MD_IDLE: begin
        if (start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = MD_LOAD;
        end
      end
      MD_BUSY: begin
        // cnt==1 marks the last occupied cycle.
        if (cnt == CNT_W'(1)) begin
          state_nxt = MD_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer: load-use, ID-resolved branch/jr operands and mult/div occupancy.
// Combinational controls from registered MD state; optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_Jump,
  input  logic        ID_MDStart,
  input  logic        ID_MDRead,
  input  logic [4:0]  EX_rd,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic [4:0]  MEM_rd,
  input  logic        MEM_MemRead,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        MD_Busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount,
`endif
  output logic [1:0]  StallReason
);

  logic ex_match, mem_match;
  logic lu, br, mdh;
  logic stall, redirect;
  stall_reason_e reason;

  assign ex_match  = reg_match(EX_rd,  ID_rs, ID_rt, ID_UseRs, ID_UseRt);
  assign mem_match = reg_match(MEM_rd, ID_rs, ID_rt, ID_UseRs, ID_UseRt);

  assign lu  = EX_MemRead & ex_match;
  // Branches and jr/jalr compare operands in ID, so an in-flight ALU result or a load in MEM is too late.
  assign br  = (ID_Branch | ID_Jump) & ((EX_RegWrite & ex_match) | (MEM_MemRead & mem_match));
  assign mdh = MD_Busy & (ID_MDStart | ID_MDRead);

  assign stall    = !reset & (lu | br | mdh);
  assign redirect = (ID_Branch & ID_BranchTaken) | ID_Jump;

  always_comb begin
    reason = SR_NONE;
    if (reset)    reason = SR_NONE;
    else if (mdh) reason = SR_MDBUSY;
    else if (lu)  reason = SR_LOADUSE;
    else if (br)  reason = SR_BRANCH;
  end

  assign PC_Write     = !stall;
  assign IF_ID_Write  = !stall;
  assign ID_EX_Bubble = stall;
  assign IF_ID_Flush  = !reset & !stall & redirect;
  assign StallReason  = reason;

  md_occupancy_fsm #(
    .MD_CYCLES(MD_CYCLES),
    .CNT_W    (CNT_W)
  ) u_md_fsm (
    .clk    (clk),
    .reset  (reset),
    .start  (ID_MDStart & !stall),
    .md_busy(MD_Busy)
  );

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      StallCycles <= StallCycles + {31'd0, stall};
      FlushCount  <= FlushCount + {31'd0, IF_ID_Flush};
    end
  end
`endif

endmodule
